// File: rtl/alu_cmd_sequencer_if.sv
// Bus bundle between the command sequencer and its environment: the input
// word stream, the operand/opcode lines toward the ALU, the captured result
// stream and the completed-operation counter.
interface alu_cmd_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OP_W-1:0]  alu_op;
  logic [WIDTH-1:0] alu_f;
  logic [3:0]       alu_fr;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_f;
  logic [3:0]       res_fr;
  logic [CNT_W-1:0] op_count;

  // The sequencer side.
  modport slave (
    input  in_valid, in_data, alu_f, alu_fr, res_ready,
    output in_ready, alu_a, alu_b, alu_op, res_valid, res_f, res_fr, op_count
  );

  // The producer / ALU / consumer side.
  modport master (
    output in_valid, in_data, alu_f, alu_fr, res_ready,
    input  in_ready, alu_a, alu_b, alu_op, res_valid, res_f, res_fr, op_count
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of the register/ALU datapath. Collects A, B and
// opcode words from a valid/ready stream, holds them on the ALU inputs, waits
// one settle cycle, captures result and flags, and offers them downstream on
// a valid/ready output. Counts results accepted by the consumer.
module alu_cmd_sequencer #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4,
  parameter int CNT_W = 16
) (
  input logic                 clk,
  input logic                 rst,
  alu_cmd_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    EXEC   = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_f_q, res_f_d;
  logic [3:0]       res_fr_q, res_fr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_ready;
  logic             in_xfer;
  logic             out_xfer;

  // Ready depends only on state and reset, never on in_valid, and is low
  // while reset is held.
  assign in_ready = !rst && (state_q == GET_A || state_q == GET_B || state_q == GET_OP);
  assign in_xfer  = bus.in_valid && in_ready;
  assign out_xfer = res_valid_q && bus.res_ready;

  // Next-state and datapath-load decisions for the whole sequencer.
  always_comb begin
    // NOTE: every _d gets its hold value first, so no path through the case
    // leaves a signal unassigned and no latch is inferred.
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    res_valid_d = res_valid_q;
    res_f_d     = res_f_q;
    res_fr_d    = res_fr_q;
    count_d     = count_q;

    unique case (state_q)
      GET_A: if (in_xfer) begin
        a_d     = bus.in_data;
        state_d = GET_B;
      end
      GET_B: if (in_xfer) begin
        b_d     = bus.in_data;
        state_d = GET_OP;
      end
      GET_OP: if (in_xfer) begin
        op_d    = bus.in_data[OP_W-1:0];
        state_d = EXEC;
      end
      // Operands have been stable on the ALU for a full cycle: sample it.
      EXEC: begin
        res_f_d     = bus.alu_f;
        res_fr_d    = bus.alu_fr;
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: if (out_xfer) begin
        res_valid_d = 1'b0;
        count_d     = count_q + CNT_W'(1);
        state_d     = GET_A;
      end
      default: state_d = GET_A;
    endcase
  end

  // State register with synchronous reset; reset wins over any handshake.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled only on the clock edge, so it is tested inside
    // the clocked block rather than in the sensitivity list.
    if (rst) begin
      state_q     <= GET_A;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      res_valid_q <= 1'b0;
      res_f_q     <= '0;
      res_fr_q    <= '0;
      count_q     <= '0;
    end else begin
      // NOTE: non-blocking updates so every register sees pre-edge values.
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      res_valid_q <= res_valid_d;
      res_f_q     <= res_f_d;
      res_fr_q    <= res_fr_d;
      count_q     <= count_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_op    = op_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_f     = res_f_q;
  assign bus.res_fr    = res_fr_q;
  assign bus.op_count  = count_q;

endmodule
